out_port: RTL
=============

// Module: out_port
// PURPOSE
//  Output port: the reader side of the accumulator's bus write. Captures the 8-bit
//  bus word on the active-low load strobe LO (same polarity as the accumulator's IA).
//  Buffers words in a small FIFO and presents them to an external consumer
//  (display/host) over a valid/ready handshake, decoupling CPU timing from the consumer.
// PARAMETERS
//  WIDTH   8   data width of bus words
//  DEPTH   4   FIFO entries; power of two, >=2
//  CW      3   count width = $clog2(DEPTH+1)
// PORTS
//  clk      in   1      single clock, all state on rising edge
//  rst      in   1      synchronous reset, active-high
//  LO       in   1      load strobe, active-low; capture Din this cycle
//  Din      in   WIDTH  bus word (accumulator output when EA is active)
//  o_data   out  WIDTH  head-of-FIFO word; valid when o_valid=1
//  o_valid  out  1      FIFO not empty
//  o_ready  in   1      consumer accepts o_data this cycle
//  full     out  1      count==DEPTH
//  empty    out  1      count==0
//  count    out  CW     occupancy 0..DEPTH
//  ovf      out  1      sticky: a load was dropped because FIFO was full
// BEHAVIOUR
//  - Clock/reset: one clock clk; rst synchronous, active-high, evaluated at posedge.
//  - Reset: wr_ptr=0, rd_ptr=0, count=0, ovf=0 -> o_valid=0, empty=1, full=0,
//    o_data=0. Storage array not reset. Reset wins over any load/pop that cycle.
//  - push = !LO && (!full || pop). pop = o_valid && o_ready.
//  - Push: mem[wr_ptr]<=Din, wr_ptr<=wr_ptr+1 (wraps modulo DEPTH).
//  - Pop: rd_ptr<=rd_ptr+1 (wraps modulo DEPTH).
//  - count: +1 push only, -1 pop only, unchanged on both or neither.
//  - Latency: word loaded at edge N appears on o_data with o_valid=1 after edge N
//    (first-word-fall-through, 1 cycle load-to-valid).
//  - o_data = mem[rd_ptr] when !empty, else 0 (combinational from registered state).
//  - Full + load + pop same cycle: both accepted, count stays DEPTH, no ovf.
//  - Full + load, no pop: word dropped, ovf<=1; ovf stays 1 until rst.
//  - Empty + o_ready: no pop, no pointer change (o_valid=0).
//  - Empty + load + o_ready: push only; word valid next cycle, not passed through.
//  - LO held low N cycles = N pushes (level-sensitive, one word per cycle).
//  - Handshake: o_data/o_valid stable while o_valid=1 and o_ready=0.
//  - rst mid-stream: all buffered words discarded; o_valid=0 the cycle after.
//  - No X propagation: LO=X treated as undefined, bench must drive LO known.
// TESTING
//  1 rst=1 2 cycles -> count=0, empty=1, o_valid=0, o_data=0, ovf=0.
//  2 LO=0 Din=8'hA5 one cycle, o_ready=0 -> next cycle o_valid=1, o_data=A5,
//    count=1; hold 5 cycles -> o_data stays A5; o_ready=1 one cycle -> empty=1.
//  3 Load 11,22,33,44 back-to-back, o_ready=0 -> full=1, count=4; then o_ready=1
//    -> o_data sequence 11,22,33,44 on consecutive cycles, then empty.
//  4 Full, LO=0 Din=55, o_ready=0 -> ovf=1, count=4, 55 never appears;
//    ovf stays 1 after drain until rst.
//  5 Full, LO=0 Din=66 with o_ready=1 -> count stays 4, ovf=0, 66 read last;
//    6 load/pop cycles wrap pointers, order preserved.
//  6 Load 3 words, rst=1 while o_ready=1 -> next cycle count=0, o_valid=0.

Source files
------------

// File: rtl/out_port_if.sv
// -----------------------------------------------------------------------------
// out_port_if
// Bus bundle between the output port and its surroundings.
//   master : drives the load strobe LO, bus word Din and consumer ready o_ready;
//            observes the FIFO head word, valid flag and status outputs.
//   slave  : the out_port itself.
// Signals:
//   LO      load strobe, active-low; Din is captured on a cycle where LO=0
//   Din     bus word from the accumulator
//   o_data  head-of-FIFO word, meaningful when o_valid=1
//   o_valid FIFO not empty
//   o_ready consumer accepts o_data this cycle
//   full    occupancy equals DEPTH
//   empty   occupancy equals zero
//   count   occupancy 0..DEPTH
//   ovf     sticky flag: a load was dropped because the FIFO was full
// -----------------------------------------------------------------------------
interface out_port_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
);
  logic             LO;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ready;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             ovf;

  modport master (
    output LO, Din, o_ready,
    input  o_data, o_valid, full, empty, count, ovf
  );

  modport slave (
    input  LO, Din, o_ready,
    output o_data, o_valid, full, empty, count, ovf
  );
endinterface

// File: rtl/out_port.sv
// -----------------------------------------------------------------------------
// out_port
// Reader side of the accumulator's bus write. Each cycle the active-low strobe
// LO is low, the bus word Din is pushed into a small first-word-fall-through
// FIFO; the head word is offered to an external consumer with valid/ready.
// A load that finds the FIFO full (and no simultaneous pop) is dropped and
// raises the sticky ovf flag, which only rst clears.
// Ports:
//   clk  in  single clock, all state on the rising edge
//   rst  in  synchronous reset, active-high; wins over load/pop in that cycle
//   bus  slave modport of out_port_if (LO, Din, o_ready in;
//        o_data, o_valid, full, empty, count, ovf out)
// -----------------------------------------------------------------------------
module out_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  out_port_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is deliberately left out of reset; empty/o_data masking hides it.
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             ovf_r;

  logic             full_s;
  logic             empty_s;
  logic             load_s;
  logic             push_s;
  logic             pop_s;
  logic [CW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] o_data_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == CW'(0));
  assign load_s  = (bus.LO == 1'b0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a load.
  assign pop_s   = !empty_s && bus.o_ready;
  assign push_s  = load_s && (!full_s || pop_s);

  // Next occupancy: +1 push only, -1 pop only, otherwise unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      if (load_s && !push_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Storage write; a word pushed during rst is harmless since pointers reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.Din;
    end
  end

  // Head word, forced to zero while empty so stale storage never leaks out.
  always_comb begin
    o_data_s = {WIDTH{1'b0}};
    if (!empty_s) begin
      o_data_s = mem_r[rd_ptr_r];
    end else begin
      o_data_s = {WIDTH{1'b0}};
    end
  end

  assign bus.o_data  = o_data_s;
  assign bus.o_valid = !empty_s;
  assign bus.full    = full_s;
  assign bus.empty   = empty_s;
  assign bus.count   = count_r;
  assign bus.ovf     = ovf_r;

endmodule
